// File: rtl/usb_tx_sched_pkg.sv
// Shared constants for the FT2232H transmit scheduler: packet headers,
// packet lengths and scheduler state encodings.
package usb_tx_sched_pkg;

  // Header nibbles that open each packet type on the wire
  localparam logic [3:0] HDR_FFT = 4'hF;
  localparam logic [3:0] HDR_RAW = 4'hA;

  // Packet lengths in bytes
  localparam int unsigned LEN_FFT = 8;
  localparam int unsigned LEN_RAW = 4;

  // Scheduler states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND_FFT = 2'd1;
  localparam logic [1:0] ST_SEND_RAW = 2'd2;

  // Index of the final byte of a packet of the given length
  function automatic logic [2:0] last_idx(input int unsigned len);
    return 3'(len - 1);
  endfunction

endpackage

// File: rtl/usb_byte_serializer.sv
// Shifts a latched packet out one byte at a time over the FT2232H write
// handshake. A byte moves only on an edge where wr_n and txe_n are both low,
// so back-pressure simply freezes the current byte on the pins.
module usb_byte_serializer #(
  parameter int unsigned USB_DATA_WIDTH = 8,
  parameter int unsigned MAX_BYTES      = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   load_i,
  input  logic [2:0]                             last_idx_i,
  input  logic [MAX_BYTES*USB_DATA_WIDTH-1:0]    word_i,
  input  logic                                   ft_txe_n_i,
  output logic [USB_DATA_WIDTH-1:0]              ft_data_o,
  output logic                                   ft_wr_n_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int unsigned WW = MAX_BYTES * USB_DATA_WIDTH;

  logic [WW-1:0]             shift_r;
  logic [2:0]                idx_r;
  logic [2:0]                last_r;
  logic [USB_DATA_WIDTH-1:0] data_r;
  logic                      wr_n_r;
  logic                      busy_r;
  logic                      xfer_s;

  assign xfer_s    = ~wr_n_r & ~ft_txe_n_i;
  assign done_o    = xfer_s & (idx_r == last_r);
  assign ft_data_o = data_r;
  assign ft_wr_n_o = wr_n_r;
  assign busy_o    = busy_r;

  // Load a packet (byte 0 straight onto the pins), then advance one byte per transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_r <= '0;
      idx_r   <= 3'd0;
      last_r  <= 3'd0;
      data_r  <= '0;
      wr_n_r  <= 1'b1;
      busy_r  <= 1'b0;
    end else if (load_i) begin
      shift_r <= word_i << USB_DATA_WIDTH;
      data_r  <= word_i[WW-1 -: USB_DATA_WIDTH];
      idx_r   <= 3'd0;
      last_r  <= last_idx_i;
      wr_n_r  <= 1'b0;
      busy_r  <= 1'b1;
    end else if (xfer_s) begin
      if (idx_r == last_r) begin
        // Last byte taken: release the bus, keep the final byte on the pins
        idx_r  <= 3'd0;
        wr_n_r <= 1'b1;
        busy_r <= 1'b0;
      end else begin
        data_r  <= shift_r[WW-1 -: USB_DATA_WIDTH];
        shift_r <= shift_r << USB_DATA_WIDTH;
        idx_r   <= idx_r + 3'd1;
      end
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/usb_tx_sched.sv
// FT2232H transmit scheduler: arbitrates the FFT and raw-sample streams onto
// the USB write port, serializes each granted word into bytes, and raises a
// send-immediate flush after the link has been idle for a while.
module usb_tx_sched
  import usb_tx_sched_pkg::*;
#(
  parameter int unsigned USB_DATA_WIDTH = 8,
  parameter int unsigned N_WIDTH        = 10,
  parameter int unsigned FFT_WIDTH      = 25,
  parameter int unsigned RAW_WIDTH      = 14,
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned FLUSH_IDLE     = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      fft_valid_i,
  output logic                      fft_ready_o,
  input  logic [N_WIDTH-1:0]        fft_ctr_i,
  input  logic [FFT_WIDTH-1:0]      fft_re_i,
  input  logic [FFT_WIDTH-1:0]      fft_im_i,
  input  logic                      raw_valid_i,
  output logic                      raw_ready_o,
  input  logic [N_WIDTH-1:0]        raw_ctr_i,
  input  logic [RAW_WIDTH-1:0]      raw_data_i,
  input  logic                      ft_txe_n_i,
  output logic [USB_DATA_WIDTH-1:0] ft_data_o,
  output logic                      ft_wr_n_o,
  output logic                      ft_siwua_n_o,
  output logic                      busy_o
);

  localparam int unsigned PKT_W = LEN_FFT * USB_DATA_WIDTH;
  localparam int unsigned SW    = $clog2(STARVE_MAX + 1);
  localparam int unsigned IW    = $clog2(FLUSH_IDLE + 1);

  logic [1:0]       state_r;
  logic [SW-1:0]    starve_r;
  logic [IW-1:0]    idle_cnt_r;
  logic             flush_pend_r;
  logic             siwua_n_r;

  logic             idle_s;
  logic             starved_s;
  logic             grant_fft_s;
  logic             grant_raw_s;
  logic             load_s;
  logic             done_s;
  logic [PKT_W-1:0] fft_word_s;
  logic [PKT_W-1:0] raw_word_s;
  logic [PKT_W-1:0] load_word_s;
  logic [2:0]       load_last_s;

  // Packets are left-aligned so the header byte always sits in the top byte
  assign fft_word_s = {HDR_FFT, fft_ctr_i, fft_re_i, fft_im_i};
  assign raw_word_s = {HDR_RAW, raw_ctr_i, raw_data_i, 4'h0, 32'h0000_0000};

  // Raw wins a tie only once the FFT stream has had STARVE_MAX grants in a row
  assign idle_s      = (state_r == ST_IDLE) & ~rst_i;
  assign starved_s   = raw_valid_i & (starve_r == SW'(STARVE_MAX));
  assign grant_fft_s = idle_s & fft_valid_i & ~starved_s;
  assign grant_raw_s = idle_s & raw_valid_i & ~grant_fft_s;
  assign load_s      = grant_fft_s | grant_raw_s;

  assign fft_ready_o  = grant_fft_s;
  assign raw_ready_o  = grant_raw_s;
  assign ft_siwua_n_o = siwua_n_r;

  // Select the word and length handed to the serializer on a grant
  always_comb begin
    load_word_s = fft_word_s;
    load_last_s = last_idx(LEN_FFT);
    if (grant_raw_s) begin
      load_word_s = raw_word_s;
      load_last_s = last_idx(LEN_RAW);
    end else begin
      load_word_s = fft_word_s;
      load_last_s = last_idx(LEN_FFT);
    end
  end

  usb_byte_serializer #(
    .USB_DATA_WIDTH (USB_DATA_WIDTH),
    .MAX_BYTES      (LEN_FFT)
  ) u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_s),
    .last_idx_i (load_last_s),
    .word_i     (load_word_s),
    .ft_txe_n_i (ft_txe_n_i),
    .ft_data_o  (ft_data_o),
    .ft_wr_n_o  (ft_wr_n_o),
    .busy_o     (busy_o),
    .done_o     (done_s)
  );

  // Scheduler state: leave IDLE on a grant, return when the last byte transfers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_fft_s) begin
            state_r <= ST_SEND_FFT;
          end else if (grant_raw_s) begin
            state_r <= ST_SEND_RAW;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEND_FFT, ST_SEND_RAW: begin
          if (done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Count FFT grants that happened while raw was waiting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_r <= '0;
    end else if (grant_fft_s) begin
      if (!raw_valid_i) begin
        starve_r <= '0;
      end else if (starve_r == SW'(STARVE_MAX)) begin
        starve_r <= starve_r;
      end else begin
        starve_r <= starve_r + SW'(1);
      end
    end else if (grant_raw_s) begin
      starve_r <= '0;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Idle timer: one flush pulse per idle period, armed by a completed packet
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt_r   <= '0;
      flush_pend_r <= 1'b0;
      siwua_n_r    <= 1'b1;
    end else if (load_s) begin
      idle_cnt_r <= '0;
      siwua_n_r  <= 1'b1;
    end else if (done_s) begin
      idle_cnt_r   <= '0;
      flush_pend_r <= 1'b1;
      siwua_n_r    <= 1'b1;
    end else if (idle_s && flush_pend_r) begin
      if (idle_cnt_r == IW'(FLUSH_IDLE - 1)) begin
        idle_cnt_r   <= '0;
        flush_pend_r <= 1'b0;
        siwua_n_r    <= 1'b0;
      end else begin
        idle_cnt_r <= idle_cnt_r + IW'(1);
        siwua_n_r  <= 1'b1;
      end
    end else begin
      siwua_n_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Self-checking bench for usb_tx_sched: a byte-queue model predicts every
// output each cycle, and directed tests pin the model with literal bytes.
module tb_usb_tx_sched;

  localparam int STARVE_MAX = 4;
  localparam int FLUSH_IDLE = 64;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        fft_valid_i = 1'b0;
  logic [9:0]  fft_ctr_i = 10'd0;
  logic [24:0] fft_re_i = 25'd0;
  logic [24:0] fft_im_i = 25'd0;
  logic        raw_valid_i = 1'b0;
  logic [9:0]  raw_ctr_i = 10'd0;
  logic [13:0] raw_data_i = 14'd0;
  logic        ft_txe_n_i = 1'b0;
  logic        fft_ready_o, raw_ready_o, ft_wr_n_o, ft_siwua_n_o, busy_o;
  logic [7:0]  ft_data_o;

  usb_tx_sched dut (
    .clk_i(clk), .rst_i(rst_i),
    .fft_valid_i(fft_valid_i), .fft_ready_o(fft_ready_o),
    .fft_ctr_i(fft_ctr_i), .fft_re_i(fft_re_i), .fft_im_i(fft_im_i),
    .raw_valid_i(raw_valid_i), .raw_ready_o(raw_ready_o),
    .raw_ctr_i(raw_ctr_i), .raw_data_i(raw_data_i),
    .ft_txe_n_i(ft_txe_n_i), .ft_data_o(ft_data_o), .ft_wr_n_o(ft_wr_n_o),
    .ft_siwua_n_o(ft_siwua_n_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: bytes still to leave the pins, held pin byte, starvation, flush timer
  logic [7:0] m_q[$];
  logic [7:0] m_data = 8'h00;
  int  m_starve = 0;
  bit  m_pending = 1'b0;
  int  m_idle = 0;
  bit  m_flush = 1'b0;

  // Observations collected for the directed tests
  logic [7:0] cap_q[$];
  byte        gl_kind[$];
  int         gl_cyc[$];
  int         n_wrlow = 0;
  int         n_flush = 0;
  int         cyc = 0;

  // Compare DUT with the model, log observations, then advance the model over the next edge
  always @(negedge clk) begin
    bit e_idle, e_gf, e_gr;
    logic [63:0] w;
    logic [31:0] r;
    cyc++;
    if (rst_i) begin
      m_q.delete(); m_data = 8'h00; m_starve = 0; m_pending = 1'b0; m_idle = 0; m_flush = 1'b0;
    end
    e_idle = (m_q.size() == 0) && !rst_i;
    e_gf   = e_idle && fft_valid_i && !(raw_valid_i && m_starve == STARVE_MAX);
    e_gr   = e_idle && raw_valid_i && !e_gf;
    chk("fft_ready", fft_ready_o, e_gf);
    chk("raw_ready", raw_ready_o, e_gr);
    chk("ft_wr_n", ft_wr_n_o, (m_q.size() == 0));
    chk("ft_data", ft_data_o, m_data);
    chk("busy", busy_o, (m_q.size() != 0));
    chk("ft_siwua_n", ft_siwua_n_o, !m_flush);

    if (!rst_i) begin
      if (!ft_wr_n_o) n_wrlow++;
      if (!ft_siwua_n_o) n_flush++;
      if (!ft_wr_n_o && !ft_txe_n_i) cap_q.push_back(ft_data_o);
      if (fft_ready_o && fft_valid_i) begin gl_kind.push_back("F"); gl_cyc.push_back(cyc); end
      if (raw_ready_o && raw_valid_i) begin gl_kind.push_back("R"); gl_cyc.push_back(cyc); end
    end

    m_flush = 1'b0;
    if (!rst_i) begin
      if (m_q.size() != 0) begin
        if (!ft_txe_n_i) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_pending = 1'b1;
            m_idle = 0;
          end else begin
            m_data = m_q[0];
          end
        end
      end else if (e_gf) begin
        w = {4'hF, fft_ctr_i, fft_re_i, fft_im_i};
        for (int i = 0; i < 8; i++) m_q.push_back(w[63-8*i -: 8]);
        m_data = m_q[0];
        m_idle = 0;
        if (raw_valid_i) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else m_starve = 0;
      end else if (e_gr) begin
        r = {4'hA, raw_ctr_i, raw_data_i, 4'h0};
        for (int i = 0; i < 4; i++) m_q.push_back(r[31-8*i -: 8]);
        m_data = m_q[0];
        m_idle = 0;
        m_starve = 0;
      end else if (m_pending) begin
        m_idle++;
        if (m_idle == FLUSH_IDLE) begin
          m_flush = 1'b1;
          m_pending = 1'b0;
          m_idle = 0;
        end
      end
    end
  end

  // Wait (bounded) for the given ready, then release valid after the accepting edge
  task automatic wait_accept(input bit is_fft);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (is_fft ? fft_ready_o : raw_ready_o) break;
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: actual=no_ready expected=ready");
    end
    @(posedge clk); #1;
    if (is_fft) fft_valid_i = 1'b0; else raw_valid_i = 1'b0;
  endtask

  task automatic send_fft(input logic [9:0] c, input logic [24:0] re, input logic [24:0] im);
    fft_ctr_i = c; fft_re_i = re; fft_im_i = im; fft_valid_i = 1'b1;
    wait_accept(1'b1);
  endtask

  task automatic send_raw(input logic [9:0] c, input logic [13:0] s);
    raw_ctr_i = c; raw_data_i = s; raw_valid_i = 1'b1;
    wait_accept(1'b0);
  endtask

  // Wait (bounded) until no packet is in progress
  task automatic wait_idle();
    int n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (!busy_o && ft_wr_n_o) break;
      n++;
    end
    if (n >= 500) begin
      n_checks++; n_err++;
      $display("FAIL idle_timeout: actual=busy expected=idle");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[], input int len);
    chk({name, "_count"}, cap_q.size(), len);
    for (int i = 0; i < len && i < cap_q.size(); i++) chk({name, "_byte"}, cap_q[i], exp[i]);
  endtask

  initial begin
    logic [7:0] exp_fft[];
    logic [7:0] exp_raw[];
    logic [7:0] exp_raw2[];
    byte        exp_order[];
    exp_fft   = '{8'hFA, 8'h97, 8'h57, 8'h9B, 8'hDF, 8'hFF, 8'hFF, 8'hFF};
    exp_raw   = '{8'hA0, 8'h0E, 8'hAB, 8'hC0};
    exp_raw2  = '{8'hAF, 8'hFD, 8'h23, 8'h40};
    exp_order = '{"F", "F", "F", "F", "R", "F", "F", "F", "F", "R"};

    // Reset: valid high must not produce ready while reset is asserted
    rst_i = 1'b1;
    fft_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_n", ft_wr_n_o, 1'b1);
    chk("rst_siwua_n", ft_siwua_n_o, 1'b1);
    chk("rst_data", ft_data_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_fft_ready", fft_ready_o, 1'b0);
    fft_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single FFT word, no back-pressure
    cap_q.delete(); n_wrlow = 0;
    send_fft(10'h2A5, 25'h1ABCDEF, 25'h1FFFFFF);
    wait_idle();
    check_bytes("fft1", exp_fft, 8);
    chk("fft1_wrlow_cycles", n_wrlow, 8);

    // Raw word
    cap_q.delete(); n_wrlow = 0;
    send_raw(10'd3, 14'h2ABC);
    wait_idle();
    check_bytes("raw1", exp_raw, 4);
    chk("raw1_wrlow_cycles", n_wrlow, 4);

    // Back-pressure for 5 cycles while byte 3 is on the pins
    cap_q.delete(); n_wrlow = 0;
    send_fft(10'h2A5, 25'h1ABCDEF, 25'h1FFFFFF);
    repeat (3) @(posedge clk);
    #1 ft_txe_n_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 ft_txe_n_i = 1'b0;
    wait_idle();
    check_bytes("bp", exp_fft, 8);
    chk("bp_wrlow_cycles", n_wrlow, 13);

    // Contention: both streams valid continuously
    gl_kind.delete(); gl_cyc.delete();
    fft_ctr_i = 10'h011; fft_re_i = 25'h0123456; fft_im_i = 25'h1000001;
    raw_ctr_i = 10'h022; raw_data_i = 14'h1F0F;
    fft_valid_i = 1'b1; raw_valid_i = 1'b1;
    repeat (100) @(posedge clk);
    #1 fft_valid_i = 1'b0; raw_valid_i = 1'b0;
    wait_idle();
    chk("cont_grants", (gl_kind.size() >= 10), 1'b1);
    for (int i = 0; i < 10 && i < gl_kind.size(); i++) chk("cont_order", gl_kind[i], exp_order[i]);
    if (gl_cyc.size() >= 6) begin
      chk("cont_fft_period", gl_cyc[1] - gl_cyc[0], 9);
      chk("cont_fft_to_raw", gl_cyc[4] - gl_cyc[3], 9);
      chk("cont_raw_to_fft", gl_cyc[5] - gl_cyc[4], 5);
    end

    // Flush: one pulse after the idle period, none for the next 200+ cycles
    n_flush = 0;
    repeat (300) @(posedge clk);
    #1;
    chk("flush_pulses", n_flush, 1);

    // Reset during byte 4 of an FFT packet
    send_fft(10'h155, 25'h0AAAAAA, 25'h1555555);
    repeat (4) @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_wr_n", ft_wr_n_o, 1'b1);
    chk("mid_rst_data", ft_data_o, 8'h00);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_siwua_n", ft_siwua_n_o, 1'b1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    cap_q.delete();
    send_raw(10'h3FF, 14'h1234);
    wait_idle();
    check_bytes("post_rst", exp_raw2, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
